// File: rtl/coco_line_prefetch.sv
// Video line prefetcher: fetches one scan line from SDRAM in BURST-word requests
// into a ping-pong line buffer, trimming leading/trailing words for any alignment.
module coco_line_prefetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 25,
  parameter int BUF_AW = 9,
  parameter int BURST  = 2,
  parameter int OFFS_W = 10
) (
  input  logic              fast_clk,
  input  logic              RESET_N,
  input  logic              LINE_START,
  input  logic [ADDR_W-1:0] LINE_BASE,
  input  logic [OFFS_W-1:0] HOR_OFFSET,
  input  logic [BUF_AW:0]   WORD_COUNT,
  input  logic [1:0]        WRAP_SEL,
  output logic              SDRAM_VID_REQ,
  output logic [ADDR_W-1:0] SDRAM_VID_ADDR,
  input  logic              SDRAM_VID_ACK,
  input  logic              SDRAM_VID_READY,
  input  logic [DATA_W-1:0] SDRAM_DOUT,
  output logic [BUF_AW:0]   BUFF_ADD,
  output logic [DATA_W-1:0] BUFF_DATA_O,
  output logic              BUFFER_WRITE,
  output logic              FILL_BANK,
  output logic              LINE_DONE,
  output logic              OVERRUN
);

  localparam int LOG2B = $clog2(BURST);
  // Counter width covers skip + WORD_COUNT rounded up to a whole burst.
  localparam int CW    = BUF_AW + 2;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] base_r;
  logic [1:0]        wrap_r;
  logic [CW-1:0]     skip_r, end_r, req_total, beat_total;
  logic [OFFS_W-1:0] fetch_off;
  logic [CW-1:0]     req_cnt, beat_cnt;
  logic [BUF_AW-1:0] wr_idx;
  logic              req_r, fill_bank_r, overrun_r, line_done_c;
  logic [ADDR_W-1:0] addr_r;

  logic              keep_p0;
  logic              wr_vld_p1;
  logic [DATA_W-1:0] wr_data_p1;
  logic [BUF_AW:0]   wr_add_p1;

  logic [OFFS_W-1:0] lo_mask;
  logic [CW-1:0]     skip_in, end_in, reqs_in;

  function automatic logic [OFFS_W-1:0] wrap_mask(input logic [1:0] sel);
    int w;
    logic [OFFS_W-1:0] m;
    case (sel)
      2'd0:    w = 7;
      2'd1:    w = 8;
      2'd2:    w = 9;
      default: w = OFFS_W;
    endcase
    for (int i = 0; i < OFFS_W; i++) m[i] = (i < w);
    return m;
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [OFFS_W-1:0] off,
                                                  input logic [1:0]        sel);
    logic [OFFS_W-1:0] woff;
    woff = off & wrap_mask(sel);
    return base + (ADDR_W'(woff) << 1);
  endfunction

  assign lo_mask = OFFS_W'(BURST - 1);
  assign skip_in = CW'(HOR_OFFSET & lo_mask);
  assign end_in  = skip_in + CW'(WORD_COUNT);
  assign reqs_in = (end_in + CW'(BURST - 1)) >> LOG2B;

  always_ff @(posedge fast_clk) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    line_done_c = 1'b0;
    case (state)
      IDLE:     if (LINE_START) state_nxt = (WORD_COUNT == '0) ? DONE : ISSUE;
      ISSUE:    state_nxt = WAIT_ACK;
      WAIT_ACK: if (SDRAM_VID_ACK)
                  state_nxt = (req_cnt + CW'(1) == req_total) ? DRAIN : ISSUE;
      DRAIN:    if (beat_cnt == beat_total) state_nxt = DONE;
      DONE: begin
        line_done_c = 1'b1;
        state_nxt   = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Line geometry is only meaningful while a line is active, so it is not reset.
  always_ff @(posedge fast_clk) begin
    if (state == IDLE && LINE_START) begin
      base_r     <= LINE_BASE;
      wrap_r     <= WRAP_SEL;
      skip_r     <= skip_in;
      end_r      <= end_in;
      req_total  <= reqs_in;
      beat_total <= reqs_in << LOG2B;
    end
  end

  // Beats are counted only inside a line; stale returns after reset fall on IDLE.
  assign keep_p0 = SDRAM_VID_READY && (state != IDLE) &&
                   (beat_cnt >= skip_r) && (beat_cnt < end_r);

  always_ff @(posedge fast_clk) begin
    if (!RESET_N) begin
      req_r       <= 1'b0;
      addr_r      <= '0;
      fill_bank_r <= 1'b0;
      overrun_r   <= 1'b0;
      fetch_off   <= '0;
      req_cnt     <= '0;
      beat_cnt    <= '0;
      wr_idx      <= '0;
      wr_vld_p1   <= 1'b0;
      wr_data_p1  <= '0;
      wr_add_p1   <= '0;
    end else begin
      overrun_r <= LINE_START && (state != IDLE);
      if (state == IDLE && LINE_START) begin
        fill_bank_r <= ~fill_bank_r;
        fetch_off   <= HOR_OFFSET & ~lo_mask;
        req_cnt     <= '0;
        beat_cnt    <= '0;
        wr_idx      <= '0;
      end
      if (state == ISSUE) begin
        req_r  <= 1'b1;
        addr_r <= line_addr(base_r, fetch_off, wrap_r);
      end
      if (state == WAIT_ACK && SDRAM_VID_ACK) begin
        req_r     <= 1'b0;
        req_cnt   <= req_cnt + CW'(1);
        fetch_off <= fetch_off + OFFS_W'(BURST);
      end
      if (SDRAM_VID_READY && state != IDLE) beat_cnt <= beat_cnt + CW'(1);
      // p0 -> p1: kept beat registered into the buffer write port
      wr_vld_p1 <= keep_p0;
      if (keep_p0) begin
        wr_data_p1 <= SDRAM_DOUT;
        wr_add_p1  <= {fill_bank_r, wr_idx};
        wr_idx     <= wr_idx + BUF_AW'(1);
      end
    end
  end

  assign SDRAM_VID_REQ  = req_r;
  assign SDRAM_VID_ADDR = addr_r;
  assign BUFF_ADD       = wr_add_p1;
  assign BUFF_DATA_O    = wr_data_p1;
  assign BUFFER_WRITE   = wr_vld_p1;
  assign FILL_BANK      = fill_bank_r;
  assign LINE_DONE      = line_done_c;
  assign OVERRUN        = overrun_r;

endmodule

// File: tb/tb_coco_line_prefetch.sv
// Directed bench for coco_line_prefetch: table of line fetches plus overrun and
// mid-line reset sequences, against a behavioural SDRAM port.
module tb_coco_line_prefetch;
  localparam int DATA_W = 16, ADDR_W = 25, BUF_AW = 9, BURST = 2, OFFS_W = 10;

  logic              fast_clk = 1'b0;
  logic              RESET_N = 1'b0;
  logic              LINE_START = 1'b0;
  logic [ADDR_W-1:0] LINE_BASE = '0;
  logic [OFFS_W-1:0] HOR_OFFSET = '0;
  logic [BUF_AW:0]   WORD_COUNT = '0;
  logic [1:0]        WRAP_SEL = '0;
  logic              SDRAM_VID_REQ;
  logic [ADDR_W-1:0] SDRAM_VID_ADDR;
  logic              SDRAM_VID_ACK = 1'b0;
  logic              SDRAM_VID_READY = 1'b0;
  logic [DATA_W-1:0] SDRAM_DOUT = '0;
  logic [BUF_AW:0]   BUFF_ADD;
  logic [DATA_W-1:0] BUFF_DATA_O;
  logic              BUFFER_WRITE, FILL_BANK, LINE_DONE, OVERRUN;

  always #5 fast_clk = ~fast_clk;

  coco_line_prefetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUF_AW(BUF_AW),
                       .BURST(BURST), .OFFS_W(OFFS_W)) dut (
    .fast_clk(fast_clk), .RESET_N(RESET_N), .LINE_START(LINE_START),
    .LINE_BASE(LINE_BASE), .HOR_OFFSET(HOR_OFFSET), .WORD_COUNT(WORD_COUNT),
    .WRAP_SEL(WRAP_SEL), .SDRAM_VID_REQ(SDRAM_VID_REQ), .SDRAM_VID_ADDR(SDRAM_VID_ADDR),
    .SDRAM_VID_ACK(SDRAM_VID_ACK), .SDRAM_VID_READY(SDRAM_VID_READY),
    .SDRAM_DOUT(SDRAM_DOUT), .BUFF_ADD(BUFF_ADD), .BUFF_DATA_O(BUFF_DATA_O),
    .BUFFER_WRITE(BUFFER_WRITE), .FILL_BANK(FILL_BANK), .LINE_DONE(LINE_DONE),
    .OVERRUN(OVERRUN));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SDRAM word content is the word address itself, truncated to 16 bits.
  function automatic logic [DATA_W-1:0] dat(input logic [ADDR_W-1:0] a);
    return a[16:1];
  endfunction

  function automatic logic [OFFS_W-1:0] tb_mask(input logic [1:0] sel);
    case (sel)
      2'd0:    return 10'h07F;
      2'd1:    return 10'h0FF;
      2'd2:    return 10'h1FF;
      default: return 10'h3FF;
    endcase
  endfunction

  bit                ovl_mode = 1'b0;
  logic [ADDR_W-1:0] rq_q[$];
  logic [ADDR_W-1:0] req_log[$];
  logic [DATA_W-1:0] wd_log[$];
  logic [BUF_AW:0]   wa_log[$];
  int                done_cnt = 0, ovr_cnt = 0, hs_viol = 0, late_wr = 0;
  bit                prev_req = 1'b0, prev_ack = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(negedge fast_clk) begin
    if (SDRAM_VID_REQ && SDRAM_VID_ACK) begin
      rq_q.push_back(SDRAM_VID_ADDR);
      req_log.push_back(SDRAM_VID_ADDR);
    end
    if (prev_req && !prev_ack && !SDRAM_VID_REQ) hs_viol++;
    if (prev_req && !prev_ack && SDRAM_VID_REQ && SDRAM_VID_ADDR !== prev_addr) hs_viol++;
    prev_req  = SDRAM_VID_REQ;
    prev_ack  = SDRAM_VID_ACK;
    prev_addr = SDRAM_VID_ADDR;
    if (BUFFER_WRITE) begin
      wd_log.push_back(BUFF_DATA_O);
      wa_log.push_back(BUFF_ADD);
      if (done_cnt > 0) late_wr++;
    end
    if (LINE_DONE) begin
      if (BUFFER_WRITE) late_wr++;
      done_cnt++;
    end
    if (OVERRUN) ovr_cnt++;
  end

  int ack_dly = 0, ack_tgt = 1;
  always @(posedge fast_clk) begin
    #1;
    if (SDRAM_VID_ACK) SDRAM_VID_ACK = 1'b0;
    else if (SDRAM_VID_REQ) begin
      if (ack_dly >= ack_tgt) begin
        SDRAM_VID_ACK = 1'b1;
        ack_dly = 0;
        ack_tgt = ovl_mode ? int'($urandom_range(0, 5)) : 1;
      end else ack_dly++;
    end
  end

  int wait_left = 0, beats_left = 0;
  logic [ADDR_W-1:0] cur = '0;
  always @(posedge fast_clk) begin
    #1;
    SDRAM_VID_READY = 1'b0;
    if (beats_left > 0) begin
      SDRAM_VID_READY = 1'b1;
      SDRAM_DOUT = dat(cur + ADDR_W'(2 * (BURST - beats_left)));
      beats_left--;
    end else if (wait_left > 0) wait_left--;
    else if (rq_q.size() > 0) begin
      cur = rq_q.pop_front();
      wait_left = ovl_mode ? int'($urandom_range(3, 10)) - 1 : 0;
      beats_left = BURST;
    end
  end

  function automatic bit resp_busy();
    return (beats_left > 0) || (wait_left > 0) || (rq_q.size() > 0);
  endfunction

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [OFFS_W-1:0] hoff;
    logic [BUF_AW:0]   wc;
    logic [1:0]        wrap;
    bit                ovl;
    bit                bank;
    int                nreq;
    logic [ADDR_W-1:0] a_first, a_last;
    int                nwr;
    logic [DATA_W-1:0] d_first, d_last;
    logic [BUF_AW:0]   b_first, b_last;
  } vec_t;

  vec_t vt[8];

  task automatic start_line(input vec_t v);
    req_log.delete(); wd_log.delete(); wa_log.delete();
    done_cnt = 0; ovr_cnt = 0; hs_viol = 0; late_wr = 0;
    ovl_mode = v.ovl;
    @(posedge fast_clk); #1;
    LINE_START = 1'b1; LINE_BASE = v.base; HOR_OFFSET = v.hoff;
    WORD_COUNT = v.wc; WRAP_SEL = v.wrap;
    @(posedge fast_clk); #1;
    LINE_START = 1'b0; LINE_BASE = 25'h1ABCDEF; HOR_OFFSET = 10'h3FF;
    WORD_COUNT = '0; WRAP_SEL = ~v.wrap;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 20000) begin @(negedge fast_clk); n++; end
    n = 0;
    while (resp_busy() && n < 500) begin @(posedge fast_clk); n++; end
    repeat (4) @(negedge fast_clk);
  endtask

  task automatic check_line(input vec_t v, input string p, input int exp_ovr);
    int errs = 0;
    logic [OFFS_W-1:0] w;
    logic [ADDR_W-1:0] ea;
    chk({p, " bank"}, FILL_BANK, v.bank);
    chk({p, " nreq"}, req_log.size(), v.nreq);
    if (v.nreq > 0 && req_log.size() > 0) begin
      chk({p, " addr first"}, req_log[0], v.a_first);
      chk({p, " addr last"}, req_log[$], v.a_last);
    end
    chk({p, " nwrite"}, wd_log.size(), v.nwr);
    if (v.nwr > 0 && wd_log.size() > 0) begin
      chk({p, " data first"}, wd_log[0], v.d_first);
      chk({p, " data last"}, wd_log[$], v.d_last);
      chk({p, " badd first"}, wa_log[0], v.b_first);
      chk({p, " badd last"}, wa_log[$], v.b_last);
    end
    for (int n = 0; n < wd_log.size(); n++) begin
      w  = (v.hoff + OFFS_W'(n)) & tb_mask(v.wrap);
      ea = v.base + {w, 1'b0};
      if (wd_log[n] !== ea[16:1] || wa_log[n] !== {v.bank, BUF_AW'(n)}) errs++;
    end
    chk({p, " sequence errs"}, errs, 0);
    chk({p, " line_done"}, done_cnt, 1);
    chk({p, " overrun"}, ovr_cnt, exp_ovr);
    chk({p, " req hold"}, hs_viol, 0);
    chk({p, " write after done"}, late_wr, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bank_before;
    int n;
    vt[0] = '{25'h10000, 10'd0,   10'd160, 2'd3, 1'b0, 1'b1, 80, 25'h10000, 25'h1013C, 160, 16'h8000, 16'h809F, 10'h200, 10'h29F};
    vt[1] = '{25'h10000, 10'd5,   10'd160, 2'd3, 1'b0, 1'b0, 81, 25'h10008, 25'h10148, 160, 16'h8005, 16'h80A4, 10'h000, 10'h09F};
    vt[2] = '{25'h20000, 10'd126, 10'd4,   2'd0, 1'b0, 1'b1, 2,  25'h200FC, 25'h20000, 4,   16'h007E, 16'h0001, 10'h200, 10'h203};
    vt[3] = '{25'h00400, 10'd3,   10'd5,   2'd3, 1'b0, 1'b0, 3,  25'h00404, 25'h0040C, 5,   16'h0203, 16'h0207, 10'h000, 10'h004};
    vt[4] = '{25'h01000, 10'd0,   10'd0,   2'd3, 1'b0, 1'b1, 0,  25'h0,     25'h0,     0,   16'h0,    16'h0,    10'h000, 10'h000};
    vt[5] = '{25'h03000, 10'd254, 10'd6,   2'd1, 1'b0, 1'b0, 3,  25'h031FC, 25'h03004, 6,   16'h18FE, 16'h1803, 10'h000, 10'h005};
    vt[6] = '{25'h10000, 10'd7,   10'd100, 2'd3, 1'b1, 1'b1, 51, 25'h1000C, 25'h100D4, 100, 16'h8007, 16'h806A, 10'h200, 10'h263};
    vt[7] = '{25'h10000, 10'd0,   10'd40,  2'd3, 1'b0, 1'b0, 20, 25'h10000, 25'h1004C, 40,  16'h8000, 16'h8027, 10'h000, 10'h027};

    repeat (3) @(posedge fast_clk);
    #1 RESET_N = 1'b1;
    @(negedge fast_clk);
    chk("reset ctl", {SDRAM_VID_REQ, BUFFER_WRITE, FILL_BANK, LINE_DONE, OVERRUN}, 5'b0);
    chk("reset addr", SDRAM_VID_ADDR, 0);
    chk("reset buf", {BUFF_ADD, BUFF_DATA_O}, 0);

    for (int i = 0; i < 7; i++) begin
      start_line(vt[i]);
      wait_done();
      check_line(vt[i], $sformatf("v%0d", i), 0);
    end

    // Second LINE_START while fetching.
    start_line(vt[7]);
    repeat (10) @(posedge fast_clk);
    #1;
    bank_before = FILL_BANK;
    LINE_START = 1'b1; LINE_BASE = 25'h5000; HOR_OFFSET = 10'd9; WORD_COUNT = 10'd3; WRAP_SEL = 2'd0;
    @(posedge fast_clk); #1;
    LINE_START = 1'b0;
    @(negedge fast_clk);
    chk("ovr pulse", OVERRUN, 1'b1);
    chk("ovr bank", FILL_BANK, bank_before);
    wait_done();
    check_line(vt[7], "ovr", 1);

    // Reset mid-line with returns still outstanding.
    start_line(vt[0]);
    ovl_mode = 1'b1;
    repeat (40) @(posedge fast_clk);
    #1 RESET_N = 1'b0;
    @(posedge fast_clk);
    #1 RESET_N = 1'b1;
    @(negedge fast_clk);
    chk("midrst ctl", {SDRAM_VID_REQ, BUFFER_WRITE, FILL_BANK, LINE_DONE, OVERRUN}, 5'b0);
    chk("midrst addr", SDRAM_VID_ADDR, 0);
    chk("midrst buf", {BUFF_ADD, BUFF_DATA_O}, 0);
    wd_log.delete();
    n = 0;
    while (resp_busy() && n < 2000) begin @(posedge fast_clk); n++; end
    repeat (5) @(negedge fast_clk);
    chk("stale writes", wd_log.size(), 0);
    chk("stale drained", resp_busy(), 1'b0);
    start_line(vt[0]);
    wait_done();
    check_line(vt[0], "post reset", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
